pwm_shadow_ctrl: RTL

Configuration controller between the SPI register interface and the PWM peripheral. It holds shadow copies of the PWM enable and duty registers written over SPI and commits them to the live PWM registers only at a PWM period boundary, so outputs never glitch mid-period. It also runs an optional duty-cycle fade engine that ramps the live duty toward a target in fixed steps, one step every N periods.

---
 rtl/pwm_ctrl_pkg.sv | 19 +
 rtl/pwm_shadow_ctrl_fade_engine.sv | 81 ++++++++
 rtl/pwm_shadow_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/pwm_ctrl_pkg.sv
// Shared definitions for the PWM shadow/commit controller and its fade engine.
package pwm_ctrl_pkg;

  localparam int unsigned DATA_W = 8;

  localparam int unsigned REG_EN_OUT_LO     = 'h00;
  localparam int unsigned REG_EN_OUT_HI     = 'h01;
  localparam int unsigned REG_EN_PWM_LO     = 'h02;
  localparam int unsigned REG_EN_PWM_HI     = 'h03;
  localparam int unsigned REG_DUTY_TARGET   = 'h04;
  localparam int unsigned REG_FADE_STEP     = 'h05;
  localparam int unsigned REG_FADE_INTERVAL = 'h06;

  typedef enum logic {
    IDLE = 1'b0,
    FADE = 1'b1
  } fade_state_t;

endpackage

// File: rtl/pwm_shadow_ctrl_fade_engine.sv
// Duty-cycle fade FSM: ramps duty toward target by fade_step every fade_interval+1 periods.
module pwm_fade_engine
  import pwm_ctrl_pkg::*;
#(
  parameter int unsigned W = pwm_ctrl_pkg::DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] target,
  input  logic [W-1:0] fade_step,
  input  logic [W-1:0] fade_interval,
  input  logic         period_end,
  output logic [W-1:0] duty,
  output logic         busy
);

  fade_state_t  state;
  logic [W-1:0] cnt;
  logic [W-1:0] step_val;
  logic [W:0]   sum;
  logic [W:0]   diff;

  // Widened by one bit so clamping catches both overflow and underflow.
  always_comb begin
    sum      = {1'b0, duty} + {1'b0, fade_step};
    diff     = {1'b0, duty} - {1'b0, fade_step};
    step_val = target;
    if (target > duty) begin
      if (sum < {1'b0, target})
        step_val = sum[W-1:0];
    end else begin
      if (!diff[W] && (diff[W-1:0] > target))
        step_val = diff[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      duty  <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (period_end) begin
            if (fade_step == '0) begin
              duty <= target;
            end else if (target != duty) begin
              cnt   <= '0;
              state <= FADE;
              busy  <= 1'b1;
            end
          end
        end
        FADE: begin
          if (period_end && (fade_step == '0)) begin
            duty  <= target;
            state <= IDLE;
            busy  <= 1'b0;
          end else if (duty == target) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (period_end) begin
            if (cnt == fade_interval) begin
              cnt  <= '0;
              duty <= step_val;
            end else begin
              cnt <= cnt + W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pwm_shadow_ctrl.sv
// Shadow register bank for the PWM peripheral; commits shadows to live registers on period_end.
module pwm_shadow_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = pwm_ctrl_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              period_end,
  output logic [7:0]        en_reg_out_7_0,
  output logic [7:0]        en_reg_out_15_8,
  output logic [7:0]        en_reg_pwm_7_0,
  output logic [7:0]        en_reg_pwm_15_8,
  output logic [DATA_W-1:0] pwm_duty_cycle,
  output logic              pending,
  output logic              busy
);

  logic [7:0]        sh_out_lo;
  logic [7:0]        sh_out_hi;
  logic [7:0]        sh_pwm_lo;
  logic [7:0]        sh_pwm_hi;
  logic [DATA_W-1:0] sh_duty;
  logic [DATA_W-1:0] target_q;
  logic [DATA_W-1:0] commit_target;
  logic [DATA_W-1:0] fade_step_q;
  logic [DATA_W-1:0] fade_interval_q;

  logic hit_out_lo, hit_out_hi, hit_pwm_lo, hit_pwm_hi, hit_duty;
  logic hit_step, hit_interval;
  logic wr_shadow;

  always_comb begin
    hit_out_lo   = 1'b0;
    hit_out_hi   = 1'b0;
    hit_pwm_lo   = 1'b0;
    hit_pwm_hi   = 1'b0;
    hit_duty     = 1'b0;
    hit_step     = 1'b0;
    hit_interval = 1'b0;
    if (wr_valid) begin
      case (wr_addr)
        ADDR_W'(REG_EN_OUT_LO):     hit_out_lo   = 1'b1;
        ADDR_W'(REG_EN_OUT_HI):     hit_out_hi   = 1'b1;
        ADDR_W'(REG_EN_PWM_LO):     hit_pwm_lo   = 1'b1;
        ADDR_W'(REG_EN_PWM_HI):     hit_pwm_hi   = 1'b1;
        ADDR_W'(REG_DUTY_TARGET):   hit_duty     = 1'b1;
        ADDR_W'(REG_FADE_STEP):     hit_step     = 1'b1;
        ADDR_W'(REG_FADE_INTERVAL): hit_interval = 1'b1;
        default: ;
      endcase
    end
    wr_shadow = hit_out_lo | hit_out_hi | hit_pwm_lo | hit_pwm_hi | hit_duty;
  end

  // The engine must see the newly committed target on the same edge that commits it.
  assign commit_target = period_end ? sh_duty : target_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_out_lo       <= '0;
      sh_out_hi       <= '0;
      sh_pwm_lo       <= '0;
      sh_pwm_hi       <= '0;
      sh_duty         <= '0;
      fade_step_q     <= '0;
      fade_interval_q <= '0;
    end else begin
      if (hit_out_lo)   sh_out_lo       <= wr_data[7:0];
      if (hit_out_hi)   sh_out_hi       <= wr_data[7:0];
      if (hit_pwm_lo)   sh_pwm_lo       <= wr_data[7:0];
      if (hit_pwm_hi)   sh_pwm_hi       <= wr_data[7:0];
      if (hit_duty)     sh_duty         <= wr_data;
      if (hit_step)     fade_step_q     <= wr_data;
      if (hit_interval) fade_interval_q <= wr_data;
    end
  end

  // Commit reads the pre-write shadows; a colliding write stays pending for the next period.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      target_q        <= '0;
      pending         <= 1'b0;
    end else begin
      if (period_end) begin
        en_reg_out_7_0  <= sh_out_lo;
        en_reg_out_15_8 <= sh_out_hi;
        en_reg_pwm_7_0  <= sh_pwm_lo;
        en_reg_pwm_15_8 <= sh_pwm_hi;
        target_q        <= sh_duty;
        pending         <= wr_shadow;
      end else if (wr_shadow) begin
        pending <= 1'b1;
      end
    end
  end

  pwm_fade_engine #(
    .W (DATA_W)
  ) u_fade (
    .clk           (clk),
    .rst           (rst),
    .target        (commit_target),
    .fade_step     (fade_step_q),
    .fade_interval (fade_interval_q),
    .period_end    (period_end),
    .duty          (pwm_duty_cycle),
    .busy          (busy)
  );

endmodule
